midi_tx: RTL and testbench



---
 rtl/midi_tx.sv | 205 ++++++++++++++++++++
 tb/tb_midi_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx.sv
// MIDI transmitter: queues channel-voice message words and serialises them as
// 8N1 UART bytes, optionally dropping status bytes that repeat the last one sent.
module midi_tx #(
    parameter int CLKS_PER_BIT   = 1600,
    parameter int FIFO_DEPTH     = 4,
    parameter int RUNNING_STATUS = 1
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [31:0]                 msg_data,
    input  logic                        msg_valid,
    output logic                        msg_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        dropped
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO entries hold {status, 7-bit data1, 7-bit data2}; bit 7 of data is never sent
    logic [21:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          push, pop;

    state_t        state_reg, state_next;
    logic [BW-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    byte_q_reg [3];
    logic [7:0]    byte_q_next [3];
    logic [1:0]    byte_idx_reg, byte_idx_next;
    logic [1:0]    n_bytes_reg, n_bytes_next;
    logic [7:0]    last_status_reg, last_status_next;
    logic          tx_reg, tx_next;
    logic          dropped_reg, dropped_next;
    logic          ser_busy_reg;

    logic [21:0]   head;
    logic [3:0]    head_s;
    logic [7:0]    status_byte, data1_byte, data2_byte;
    logic [1:0]    msg_len;
    logic          skip_status;
    logic          unused_msg_bits;

    assign unused_msg_bits = ^{msg_data[31:24], msg_data[15], msg_data[7]};

    assign msg_ready  = (count_reg != CW'(FIFO_DEPTH));
    assign push       = msg_valid && msg_ready;
    assign fifo_count = count_reg;
    assign tx         = tx_reg;
    assign dropped    = dropped_reg;
    // tx lags the FSM by one register stage, so busy covers that stage too
    assign busy       = (count_reg != '0) || (state_reg != IDLE) || ser_busy_reg;

    assign head        = fifo_mem[rd_ptr_reg];
    assign head_s      = head[21:18];
    assign status_byte = head[21:14];
    assign data1_byte  = {1'b0, head[13:7]};
    assign data2_byte  = {1'b0, head[6:0]};
    assign skip_status = (RUNNING_STATUS != 0) && (head_s != 4'hF) &&
                         (status_byte == last_status_reg);

    always_comb begin
        msg_len = 2'd0;
        case (head_s)
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: msg_len = 2'd3;
            4'hC, 4'hD:                   msg_len = 2'd2;
            4'hF:                         msg_len = 2'd1;
            default:                      msg_len = 2'd0;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (!push && pop)
            count_next = count_reg - CW'(1);
    end

    always_comb begin
        state_next       = state_reg;
        clk_cnt_next     = clk_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        byte_q_next      = byte_q_reg;
        byte_idx_next    = byte_idx_reg;
        n_bytes_next     = n_bytes_reg;
        last_status_next = last_status_reg;
        dropped_next     = 1'b0;
        tx_next          = 1'b1;
        pop              = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    pop = 1'b1;
                    if (msg_len == 2'd0) begin
                        dropped_next = 1'b1;
                    end else begin
                        if (skip_status) begin
                            byte_q_next[0] = data1_byte;
                            byte_q_next[1] = data2_byte;
                            n_bytes_next   = msg_len - 2'd1;
                        end else begin
                            byte_q_next[0] = status_byte;
                            byte_q_next[1] = data1_byte;
                            byte_q_next[2] = data2_byte;
                            n_bytes_next   = msg_len;
                        end
                        last_status_next = (head_s == 4'hF) ? 8'h00 : status_byte;
                        byte_idx_next    = 2'd0;
                        clk_cnt_next     = BIT_LOAD;
                        state_next       = START;
                    end
                end
            end
            START: begin
                tx_next = 1'b0;
                if (clk_cnt_reg == '0) begin
                    clk_cnt_next = BIT_LOAD;
                    shift_next   = byte_q_reg[byte_idx_reg];
                    bit_cnt_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg - BW'(1);
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (clk_cnt_reg == '0) begin
                    clk_cnt_next = BIT_LOAD;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = STOP;
                end else begin
                    clk_cnt_next = clk_cnt_reg - BW'(1);
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (clk_cnt_reg == '0) begin
                    clk_cnt_next = BIT_LOAD;
                    if (byte_idx_reg + 2'd1 < n_bytes_reg) begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg - BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {msg_data[23:16], msg_data[14:8], msg_data[6:0]};
    end

    always_ff @(posedge clock) begin
        shift_reg  <= shift_next;
        byte_q_reg <= byte_q_next;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            state_reg       <= IDLE;
            clk_cnt_reg     <= '0;
            bit_cnt_reg     <= 3'd0;
            byte_idx_reg    <= 2'd0;
            n_bytes_reg     <= 2'd0;
            last_status_reg <= 8'h00;
            tx_reg          <= 1'b1;
            dropped_reg     <= 1'b0;
            ser_busy_reg    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg       <= count_next;
            state_reg       <= state_next;
            clk_cnt_reg     <= clk_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            byte_idx_reg    <= byte_idx_next;
            n_bytes_reg     <= n_bytes_next;
            last_status_reg <= last_status_next;
            tx_reg          <= tx_next;
            dropped_reg     <= dropped_next;
            ser_busy_reg    <= (state_reg != IDLE);
        end
    end
endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: decodes the serial line and checks bytes, frame timing
// and handshake signals against a message-level reference model.
module tb_midi_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] msg_data = '0;
    logic        msg_valid = 1'b0;
    logic        msg_ready, tx, busy, dropped;
    logic [2:0]  fifo_count;

    midi_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .RUNNING_STATUS(1)) dut (
        .clock(clock), .resetn(resetn), .msg_data(msg_data), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
        .dropped(dropped)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int compared = 0;
    int mism = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // serial line decoder
    logic [7:0] cap_byte[$];
    int         cap_start[$];
    int         stop_err = 0;
    initial begin : monitor
        logic [7:0] b;
        int s;
        forever begin
            @(negedge clock);
            if (resetn && tx === 1'b0) begin
                s = cyc;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clock);
                if (tx !== 1'b1) stop_err++;
                cap_byte.push_back(b);
                cap_start.push_back(s);
            end
        end
    end

    // reference model: expected byte stream and expected start-to-start spacing
    logic [7:0] exp_byte[$];
    int         exp_gap[$];
    logic [7:0] model_last = 8'h00;

    task automatic model_add(input logic [7:0] b, input bit first);
        exp_byte.push_back(b);
        exp_gap.push_back(first ? 10*CPB + 1 : 10*CPB);
    endtask

    task automatic model_msg(input logic [31:0] m);
        logic [3:0] s;
        logic [7:0] st;
        bit first;
        s  = m[23:20];
        st = m[23:16];
        first = 1'b1;
        if (s < 4'h8) return;
        if (s == 4'hF) begin
            model_add(st, 1'b1);
            model_last = 8'h00;
            return;
        end
        if (st != model_last) begin
            model_add(st, 1'b1);
            first = 1'b0;
        end
        model_last = st;
        model_add({1'b0, m[14:8]}, first);
        if (s != 4'hC && s != 4'hD) model_add({1'b0, m[6:0]}, 1'b0);
    endtask

    int push_cyc;
    task automatic push_msg(input logic [31:0] m);
        @(negedge clock);
        for (int t = 0; t < 5000 && !msg_ready; t++) @(negedge clock);
        check("push_ready_wait", msg_ready, 1);
        msg_data  = m;
        msg_valid = 1'b1;
        @(posedge clock);
        #1;
        push_cyc  = cyc;
        msg_valid = 1'b0;
        model_msg(m);
    endtask

    function automatic logic [31:0] rand_valid_msg();
        return {8'($urandom), 4'($urandom_range(8, 15)), 4'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    task automatic drain_check(input string tag, input bit cross_gap,
                               output int fall, output int first_start);
        bit done;
        int n;
        done = 1'b0;
        fall = -1;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(posedge clock);
            #1;
            if (!busy) begin
                done = 1'b1;
                fall = cyc;
            end
        end
        check({tag, "_drain"}, 32'(done), 1);
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_tx_idle"}, tx, 1);
        first_start = (cap_start.size() != 0) ? cap_start[0] : -1;
        check({tag, "_nbytes"}, cap_byte.size(), exp_byte.size());
        n = (cap_byte.size() < exp_byte.size()) ? cap_byte.size() : exp_byte.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), cap_byte[i], exp_byte[i]);
            if (i > 0 && (exp_gap[i] == 10*CPB || cross_gap))
                check($sformatf("%s_gap%0d", tag, i), cap_start[i] - cap_start[i-1], exp_gap[i]);
        end
        check({tag, "_stop_bits"}, stop_err, 0);
        cap_byte.delete();
        cap_start.delete();
        exp_byte.delete();
        exp_gap.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n0, fall, fs, acc;
        logic rdy;
        logic [31:0] w [6];

        // reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", msg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_dropped", dropped, 0);
        resetn = 1'b1;
        repeat (2) @(posedge clock);

        // A: single 3-byte note-on, latency and total duration
        push_msg(32'h00903C64);
        n0 = push_cyc;
        check("A_count", fifo_count, 1);
        check("A_busy", busy, 1);
        drain_check("A", 1'b1, fall, fs);
        check("A_start", fs, n0 + 2);
        check("A_fall", fall, n0 + 2 + 30*CPB);

        // B: program change with masked data, then running status
        push_msg(32'h00C00585);
        n0 = push_cyc;
        push_msg(32'h00903C64);
        push_msg(32'h00904000);
        drain_check("B", 1'b1, fall, fs);
        check("B_start", fs, n0 + 2);
        check("B_fall", fall, n0 + 2 + 70*CPB + 2);

        // C: invalid status is dropped without touching last_status
        push_msg(32'h00503C64);
        check("C_drop_pre", dropped, 0);
        @(posedge clock); #1;
        check("C_drop_pulse", dropped, 1);
        check("C_count", fifo_count, 0);
        @(posedge clock); #1;
        check("C_drop_post", dropped, 0);
        check("C_busy", busy, 0);
        check("C_tx", tx, 1);
        push_msg(32'h00903C64);
        drain_check("C", 1'b1, fall, fs);

        // D: overrun the FIFO with back-to-back offers
        for (int k = 0; k < 6; k++) w[k] = rand_valid_msg();
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            rdy = msg_ready;
            msg_data  = w[k];
            msg_valid = 1'b1;
            @(posedge clock);
            #1;
            check($sformatf("D_ready%0d", k), 32'(rdy), 32'(k < 5));
            if (rdy) begin
                model_msg(w[k]);
                acc++;
            end
        end
        msg_valid = 1'b0;
        check("D_count", fifo_count, DEPTH);
        check("D_accepted", acc, 5);
        drain_check("D", 1'b1, fall, fs);

        // E: random messages (valid and invalid) with random spacing
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            push_msg({8'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom)});
        end
        drain_check("E", 1'b0, fall, fs);

        // F: reset during data bit 3 of the second byte
        push_msg(32'h00903C64);
        n0 = push_cyc;
        push_msg(32'h00B01234);
        while (cyc < n0 + 2 + 10*CPB + 4*CPB + 1) begin
            @(posedge clock);
            #1;
        end
        check("F_bit3", tx, 1);
        check("F_count_pre", fifo_count, 1);
        resetn = 1'b0;
        @(posedge clock); #1;
        check("F_tx", tx, 1);
        check("F_count", fifo_count, 0);
        check("F_busy", busy, 0);
        check("F_ready", msg_ready, 1);
        resetn = 1'b1;
        repeat (50) @(posedge clock);
        cap_byte.delete();
        cap_start.delete();
        exp_byte.delete();
        exp_gap.delete();
        stop_err = 0;
        model_last = 8'h00;
        push_msg(32'h00903C64);
        n0 = push_cyc;
        drain_check("F", 1'b1, fall, fs);
        check("F_start", fs, n0 + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
